fp32_tree8_input_packer: RTL
============================

Name: fp32_tree8_input_packer

Overview:
Upstream feeder for the 8-input FP32 adder tree. It accepts a serial stream of FP32 operands over a valid/ready handshake and packs them into 8-lane groups. Short groups are padded with -0.0. Each complete group is presented as a registered, flat 256-bit vector with valid/ready, ready to drive the tree's flat operand input. Double-buffered (fill buffer + output register) so one group can fill while the previous one waits for the consumer.

Parameters:
NUM_LANES, 8, lanes per group; must match the adder tree input count.
FP32_WIDTH, 32, width of one operand.
PAD_VALUE, 32'h8000_0000, value driven on unfilled lanes (-0.0, the additive identity for every x, including +0 and -0).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous, active-low reset.
soft_clr  input  1  synchronous discard of fill buffer and output register.
in_valid  input  1  in_data valid.
in_ready  output  1  packer can accept an element this cycle.
in_data  input  FP32_WIDTH  one FP32 operand.
in_last  input  1  closes the current group after this element (qualified by in_valid & in_ready).
out_valid  output  1  out_data_flat holds a complete group.
out_ready  input  1  consumer accepts the group.
out_data_flat  output  NUM_LANES*FP32_WIDTH  lane i at bits [(i+1)*32-1 : i*32]; lane 0 = first element of the group.
out_lane_mask  output  NUM_LANES  bit i = 1 if lane i holds a real element.
out_count  output  4  number of real elements in the group (1..8).

Behaviour:
- Reset (rst_n=0, async): fill index=0, fill_full=0, out_valid=0, out_data_flat=all lanes PAD_VALUE, out_lane_mask=0, out_count=0. All fill lanes are set to PAD_VALUE.
- Input handshake: in_ready = !fill_full && !soft_clr (combinational from registers and soft_clr). An element is accepted on an edge where in_valid && in_ready. It is written to fill lane [idx], and idx increments.
- Group close: an accepted element closes the group if idx==NUM_LANES-1 or in_last=1.
- out slot free this cycle: out_free = !out_valid || out_ready.
- Closing element accepted and out_free: at the same edge, the output register loads the fill lanes including this element. Remaining lanes load PAD_VALUE. out_lane_mask, out_count and out_valid=1 are set, then idx=0 and all fill lanes return to PAD_VALUE. Latency is 1 cycle from the closing accept to out_valid.
- Closing element accepted and out slot busy: fill_full=1 and in_ready falls. On the first edge where out_ready && out_valid, the fill buffer transfers to the output register (out_valid stays 1, data updates), and fill_full=0. There is no bubble.
- Output handshake: a group is consumed on an edge with out_valid && out_ready. If no new group transfers on that edge, out_valid=0. out_data_flat, out_lane_mask and out_count are held stable while out_valid && !out_ready.
- States (FSM): EMPTY (idx=0, !fill_full), FILLING (0<idx<8), FULL (fill_full). The output register has its own valid bit.
- in_last on the 8th element: a single group with count 8; no extra empty group is created. Zero-length groups are never produced.
- soft_clr=1: an out handshake in that cycle still counts as consumed. At the edge, the fill buffer and output register are cleared to their reset values and no transfer occurs. The input side is blocked during that cycle via in_ready=0.
- Reset mid-group: the partial group is discarded and no output is produced.
- in_data is passed through bit-exact. NaN, Inf and denormal values are not inspected or modified.

Test Plan:
- 8 back-to-back elements 0x3F800000, 0x40000000, ..., 0x41000000 (1.0..8.0), out_ready=1 -> out_valid one cycle after the 8th accept; lane0=0x3F800000, lane7=0x41000000; mask=0xFF; count=8; feeding the tree gives sum 0x42100000 (36.0).
- 3 elements 0xBF800000 ×2 and 0x80000000 with in_last on the 3rd -> lanes 3..7 = 0x80000000; mask=0x07; count=3; tree sum = 0xC0000000 (-2.0). Separately, 3× 0x80000000 with in_last -> tree sum 0x80000000 (-0 preserved).
- out_ready=0, 16 elements streamed -> group 1 held stable in the output register. in_ready=0 after the 16th accept. Raise out_ready for 1 cycle -> group 2 appears the next cycle with out_valid continuously 1, and in_ready returns to 1.
- rst_n pulsed low mid-cycle after 5 accepts -> out_valid=0 and in_ready=1 immediately. The next 8 elements form a clean group with count=8 and no residue from before reset.
- soft_clr asserted with in_valid=1, fill idx=4 and a pending output group -> in_ready=0 that cycle. Next cycle out_valid=0 and idx=0. The following 2 elements with in_last give count=2 and mask=0x03.
- Alternate in_valid, randomize out_ready over 1000 elements with random in_last -> scoreboard checks every element appears once, in order, in the correct lane, and the sum of out_count equals the number of accepted elements.

Source files
------------

// File: rtl/fp32_tree8_input_packer.sv
// Packs a serial valid/ready stream of FP32 operands into NUM_LANES-wide groups for the adder tree.
// A fill buffer collects one group while the output register holds the previous one for the consumer.
module fp32_tree8_input_packer #(
  parameter int                    NUM_LANES  = 8,
  parameter int                    FP32_WIDTH = 32,
  parameter logic [FP32_WIDTH-1:0] PAD_VALUE  = 32'h8000_0000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            soft_clr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [FP32_WIDTH-1:0]           in_data,
  input  logic                            in_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*FP32_WIDTH-1:0] out_data_flat,
  output logic [NUM_LANES-1:0]            out_lane_mask,
  output logic [3:0]                      out_count
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILLING,
    ST_FULL
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [FP32_WIDTH-1:0] r_fill [NUM_LANES];
  logic [FP32_WIDTH-1:0] r_out  [NUM_LANES];
  logic                  r_out_valid;
  logic [NUM_LANES-1:0]  r_out_mask;
  logic [3:0]            r_out_count;

  logic                  w_accept;
  logic                  w_close;
  logic                  w_out_free;
  logic                  w_consume;
  logic [3:0]            w_cnt_next;
  logic [FP32_WIDTH-1:0] w_fill_next [NUM_LANES];

  function automatic logic [NUM_LANES-1:0] lane_mask(input logic [3:0] cnt);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LANES; i++) m[i] = (4'(i) < cnt);
    return m;
  endfunction

  assign in_ready   = (r_state != ST_FULL) && !soft_clr;
  assign w_accept   = in_valid && in_ready;
  assign w_close    = w_accept && ((r_cnt == 4'(NUM_LANES - 1)) || in_last);
  assign w_out_free = !r_out_valid || out_ready;
  assign w_consume  = r_out_valid && out_ready;
  assign w_cnt_next = r_cnt + 4'd1;

  // NOTE: every element gets a value on every pass, so this stays purely combinational.
  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      w_fill_next[i] = (w_accept && (r_cnt == 4'(i))) ? in_data : r_fill[i];
    end
  end

  // NOTE: non-blocking assignments throughout, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_count <= '0;
      // NOTE: lane arrays are reset explicitly because idle lanes must read as the pad value.
      for (int i = 0; i < NUM_LANES; i++) begin
        r_fill[i] <= PAD_VALUE;
        r_out[i]  <= PAD_VALUE;
      end
    end else if (soft_clr) begin
      r_state     <= ST_EMPTY;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_mask  <= '0;
      r_out_count <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r_fill[i] <= PAD_VALUE;
        r_out[i]  <= PAD_VALUE;
      end
    end else begin
      if (w_consume) r_out_valid <= 1'b0;
      case (r_state)
        ST_FULL: begin
          // Parked group moves out on the consuming edge, so out_valid never drops.
          if (w_consume) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              r_out[i]  <= r_fill[i];
              r_fill[i] <= PAD_VALUE;
            end
            r_out_valid <= 1'b1;
            r_out_mask  <= lane_mask(r_cnt);
            r_out_count <= r_cnt;
            r_cnt       <= '0;
            r_state     <= ST_EMPTY;
          end
        end
        default: begin
          if (w_close && w_out_free) begin
            for (int i = 0; i < NUM_LANES; i++) begin
              r_out[i]  <= w_fill_next[i];
              r_fill[i] <= PAD_VALUE;
            end
            r_out_valid <= 1'b1;
            r_out_mask  <= lane_mask(w_cnt_next);
            r_out_count <= w_cnt_next;
            r_cnt       <= '0;
            r_state     <= ST_EMPTY;
          end else if (w_accept) begin
            for (int i = 0; i < NUM_LANES; i++) r_fill[i] <= w_fill_next[i];
            r_cnt   <= w_cnt_next;
            r_state <= w_close ? ST_FULL : ST_FILLING;
          end
        end
      endcase
    end
  end

  always_comb begin
    out_data_flat = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      out_data_flat[i*FP32_WIDTH +: FP32_WIDTH] = r_out[i];
    end
  end

  assign out_valid     = r_out_valid;
  assign out_lane_mask = r_out_mask;
  assign out_count     = r_out_count;

endmodule
